// File: rtl/imem_fetch_port_pkg.sv
// Shared types for the instruction-memory fetch port.
// Address/data aliases, fault causes and port FSM states.
package imem_fetch_port_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;

    typedef enum logic [1:0] {
        FETCH_FAULT__NONE,
        FETCH_FAULT__MISALIGNED,
        FETCH_FAULT__BUS_ERR,
        FETCH_FAULT__TIMEOUT
    } fetch_fault_t;

    typedef enum logic [1:0] {
        IMEM_PORT__IDLE,
        IMEM_PORT__REQ,
        IMEM_PORT__WAIT,
        IMEM_PORT__DRAIN
    } imem_port_state_t;

    function automatic logic is_word_aligned(addr_t a);
        return a[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/imem_fetch_port_if.sv
// Request/grant/response bus between the fetch port and instruction memory.
// master = fetch port, slave = memory.
interface imem_fetch_port_if;
    import imem_fetch_port_pkg::*;

    logic  imem_req;
    addr_t imem_addr;
    logic  imem_gnt;
    logic  imem_rvalid;
    data_t imem_rdata;
    logic  imem_rerr;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  imem_rerr
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output imem_rerr
    );

endinterface

// File: rtl/imem_fetch_port_watchdog.sv
// Saturating watchdog for an outstanding fetch.
// expired is high in the TIMEOUT_CYCLES-th enabled cycle after clear.
module fetch_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] TOP  = W'(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != TOP) begin
            count <= count + 1'b1;
        end
    end

    // Fires once: the count saturates past LAST on the same edge.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/imem_fetch_port.sv
// Fetch port: reads the word at pc_cur into ir on a control-FSM request,
// handling wait states, misalignment, bus errors, timeout and flush.
module imem_fetch_port
    import imem_fetch_port_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter data_t       IR_RESET_VAL   = 32'h00000013
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfsm__fetch_req,
    input  logic         cfsm__fetch_flush,
    input  addr_t        pc_cur,
    imem_fetch_port_if.master imem,
    output data_t        ir,
    output addr_t        instr_pc,
    output logic         fetch_done,
    output logic         fetch_fault,
    output fetch_fault_t fault_cause,
    output logic         busy
);

    imem_port_state_t state;
    addr_t            addr_q;
    logic             req_q;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign wd_clear  = (state == IMEM_PORT__IDLE) && cfsm__fetch_req
                       && !cfsm__fetch_flush && is_word_aligned(pc_cur);
    assign wd_enable = (state == IMEM_PORT__REQ)
                       || (state == IMEM_PORT__WAIT);

    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IMEM_PORT__IDLE;
            addr_q      <= '0;
            req_q       <= 1'b0;
            ir          <= IR_RESET_VAL;
            instr_pc    <= '0;
            fetch_done  <= 1'b0;
            fetch_fault <= 1'b0;
            fault_cause <= FETCH_FAULT__NONE;
            busy        <= 1'b0;
        end else begin
            fetch_done  <= 1'b0;
            fetch_fault <= 1'b0;
            unique case (state)
                IMEM_PORT__IDLE: begin
                    if (!cfsm__fetch_flush && cfsm__fetch_req) begin
                        if (!is_word_aligned(pc_cur)) begin
                            fetch_fault <= 1'b1;
                            fault_cause <= FETCH_FAULT__MISALIGNED;
                        end else begin
                            addr_q <= pc_cur;
                            req_q  <= 1'b1;
                            busy   <= 1'b1;
                            state  <= IMEM_PORT__REQ;
                        end
                    end
                end
                IMEM_PORT__REQ: begin
                    if (cfsm__fetch_flush) begin
                        req_q <= 1'b0;
                        if (imem.imem_gnt) begin
                            state <= IMEM_PORT__DRAIN;
                        end else begin
                            busy  <= 1'b0;
                            state <= IMEM_PORT__IDLE;
                        end
                    end else if (wd_expired) begin
                        // A grant in the timeout cycle still owes a response.
                        req_q       <= 1'b0;
                        fetch_fault <= 1'b1;
                        fault_cause <= FETCH_FAULT__TIMEOUT;
                        busy        <= imem.imem_gnt;
                        state       <= imem.imem_gnt ? IMEM_PORT__DRAIN
                                                     : IMEM_PORT__IDLE;
                    end else if (imem.imem_gnt) begin
                        req_q <= 1'b0;
                        state <= IMEM_PORT__WAIT;
                    end
                end
                IMEM_PORT__WAIT: begin
                    if (imem.imem_rvalid) begin
                        busy  <= 1'b0;
                        state <= IMEM_PORT__IDLE;
                        if (!cfsm__fetch_flush) begin
                            if (imem.imem_rerr) begin
                                fetch_fault <= 1'b1;
                                fault_cause <= FETCH_FAULT__BUS_ERR;
                            end else begin
                                ir         <= imem.imem_rdata;
                                instr_pc   <= addr_q;
                                fetch_done <= 1'b1;
                            end
                        end
                    end else if (cfsm__fetch_flush) begin
                        state <= IMEM_PORT__DRAIN;
                    end else if (wd_expired) begin
                        fetch_fault <= 1'b1;
                        fault_cause <= FETCH_FAULT__TIMEOUT;
                        state       <= IMEM_PORT__DRAIN;
                    end
                end
                IMEM_PORT__DRAIN: begin
                    if (imem.imem_rvalid) begin
                        busy  <= 1'b0;
                        state <= IMEM_PORT__IDLE;
                    end
                end
                default: begin
                    state <= IMEM_PORT__IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_port.sv
// Directed and randomized bench for imem_fetch_port, checked against
// a transaction-level model of fetch outcome and timing.
module tb_imem_fetch_port;
    import imem_fetch_port_pkg::*;

    localparam int    TO  = 8;
    localparam data_t IRV = 32'h00000013;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         fetch_req = 1'b0;
    logic         flush = 1'b0;
    addr_t        pc_cur = '0;
    data_t        ir;
    addr_t        instr_pc;
    logic         fetch_done;
    logic         fetch_fault;
    fetch_fault_t fault_cause;
    logic         busy;

    int errors = 0;
    int checks = 0;

    data_t        m_ir = IRV;
    addr_t        m_pc = '0;
    fetch_fault_t m_cause = FETCH_FAULT__NONE;

    imem_fetch_port_if bus();

    imem_fetch_port #(
        .TIMEOUT_CYCLES(TO),
        .IR_RESET_VAL  (IRV)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .cfsm__fetch_req  (fetch_req),
        .cfsm__fetch_flush(flush),
        .pc_cur           (pc_cur),
        .imem             (bus.master),
        .ir               (ir),
        .instr_pc         (instr_pc),
        .fetch_done       (fetch_done),
        .fetch_fault      (fetch_fault),
        .fault_cause      (fault_cause),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        check("ir", ir, m_ir);
        check("instr_pc", instr_pc, m_pc);
        check("fault_cause", fault_cause, m_cause);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, bus.imem_req, 1'b0);
        check({tag, "_addr"}, bus.imem_addr, 32'h0);
        check({tag, "_ir"}, ir, IRV);
        check({tag, "_pc"}, instr_pc, 32'h0);
        check({tag, "_done"}, fetch_done, 1'b0);
        check({tag, "_fault"}, fetch_fault, 1'b0);
        check({tag, "_cause"}, fault_cause, FETCH_FAULT__NONE);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    // g: cycles of grant delay; r: extra cycles after earliest rvalid.
    task automatic run_fetch(input addr_t pc, input int g, input int r,
                             input bit err, input data_t d);
        int resp;
        bit ok;
        fetch_req = 1'b1;
        pc_cur    = pc;
        step();
        fetch_req = 1'b0;
        pc_cur    = $urandom;
        if (pc[1:0] != 2'b00) begin
            m_cause = FETCH_FAULT__MISALIGNED;
            check("mis_fault", fetch_fault, 1'b1);
            check("mis_done", fetch_done, 1'b0);
            check("mis_req", bus.imem_req, 1'b0);
            check("mis_busy", busy, 1'b0);
            check_model();
            step();
            check("mis_fault_pulse", fetch_fault, 1'b0);
            check("mis_req2", bus.imem_req, 1'b0);
            return;
        end
        resp = g + 2 + r;
        ok   = (resp <= TO);
        for (int k = 1; k <= resp + 1; k++) begin
            check("done", fetch_done, ok && !err && k == resp + 1);
            check("fault", fetch_fault,
                  (ok && err && k == resp + 1) || (!ok && k == TO + 1));
            check("req", bus.imem_req, k <= g + 1);
            if (k <= g + 1) check("addr", bus.imem_addr, pc);
            check("busy", busy, k <= resp);
            bus.imem_gnt    = (k == g + 1);
            bus.imem_rvalid = (k == resp);
            bus.imem_rerr   = err && (k == resp);
            bus.imem_rdata  = (k == resp) ? d : data_t'($urandom);
            if (k <= resp) step();
        end
        if (ok && !err) begin
            m_ir = d;
            m_pc = pc;
        end else if (ok) begin
            m_cause = FETCH_FAULT__BUS_ERR;
        end else begin
            m_cause = FETCH_FAULT__TIMEOUT;
        end
        check_model();
    endtask

    initial begin
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.imem_rerr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b1;
        step();
        check_reset_outputs("rel");

        run_fetch(32'h100, 0, 0, 1'b0, 32'h00500093);
        check("zw_busy_after", busy, 1'b0);
        run_fetch(32'h102, 0, 0, 1'b0, 32'h0);
        run_fetch(32'h104, 5, 1, 1'b0, 32'h12345678);
        run_fetch(32'h108, 1, 1, 1'b1, 32'hFFFFFFFF);
        run_fetch(32'h10C, 0, 10, 1'b0, 32'hCAFEF00D);
        run_fetch(32'h110, 0, 6, 1'b0, 32'h00A00113);

        // Flush in WAIT, response arrives two cycles later.
        fetch_req = 1'b1;
        pc_cur    = 32'h300;
        step();
        fetch_req    = 1'b0;
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        flush        = 1'b1;
        step();
        flush = 1'b0;
        check("fl_busy", busy, 1'b1);
        check("fl_done", fetch_done, 1'b0);
        check("fl_fault", fetch_fault, 1'b0);
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEADBEEF;
        step();
        bus.imem_rvalid = 1'b0;
        check("fl_busy_end", busy, 1'b0);
        check("fl_done_end", fetch_done, 1'b0);
        check("fl_fault_end", fetch_fault, 1'b0);
        check_model();
        run_fetch(32'h304, 0, 0, 1'b0, 32'h00108093);

        // Flush in REQ before grant.
        fetch_req = 1'b1;
        pc_cur    = 32'h400;
        step();
        fetch_req = 1'b0;
        flush     = 1'b1;
        step();
        flush = 1'b0;
        check("flreq_req", bus.imem_req, 1'b0);
        check("flreq_busy", busy, 1'b0);
        check("flreq_done", fetch_done, 1'b0);

        for (int i = 0; i < 24; i++) begin
            addr_t pc;
            pc = addr_t'($urandom) & 32'h0000FFFF;
            if ($urandom_range(3, 0) != 0) pc[1:0] = 2'b00;
            run_fetch(pc, int'($urandom_range(4, 0)),
                      int'($urandom_range(7, 0)),
                      $urandom_range(4, 0) == 0, data_t'($urandom));
        end

        // Asynchronous reset while in WAIT.
        fetch_req = 1'b1;
        pc_cur    = 32'h500;
        step();
        fetch_req    = 1'b0;
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        reset = 1'b1;
        m_ir    = IRV;
        m_pc    = '0;
        m_cause = FETCH_FAULT__NONE;
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h0BADF00D;
        step();
        bus.imem_rvalid = 1'b0;
        check("stray_done", fetch_done, 1'b0);
        check("stray_busy", busy, 1'b0);
        check_model();
        run_fetch(32'h600, 2, 0, 1'b0, 32'h00000517);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
